// File: rtl/bfusion_operand_sequencer.sv
// Operand sequencer for a bit-fusion MAC: collects weight/activation pairs,
// packs them into 16-bit operand words per precision mode, issues one MAC op
// per packed word, drains the MAC pipeline and returns the accumulated result.
module bfusion_operand_sequencer #(
    parameter int HEADROOM        = 4,
    parameter int SCALABLE_LEVELS = 2,
    parameter int ACCU_LEN        = 50,
    parameter int MAC_LAT         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               mode,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_w,
    input  logic [7:0]               in_a,
    output logic [15:0]              mac_a,
    output logic [15:0]              mac_w,
    output logic [SCALABLE_LEVELS:0] mac_config,
    output logic                     mac_accu_rst,
    input  logic [15+HEADROOM:0]     mac_z,
    output logic [15+HEADROOM:0]     res_z,
    output logic                     res_valid,
    output logic                     busy,
    output logic                     cfg_err
);
    localparam int ZW = 16 + HEADROOM;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [9:0]    LAST_OP    = 10'(ACCU_LEN - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [2:0]      mode_q;
    logic [1:0]      pcnt;
    logic [9:0]      ops;
    logic [DW-1:0]   dcnt;
    logic [15:0]     w_pack, a_pack, w_nxt, a_nxt;
    logic [1:0]      last_pair;
    logic [2:0]      sx;
    logic [ZW-1:0]   z_shl, z_ext;
    logic            mode_ok;

    assign mac_config = mode_q[2 -: SCALABLE_LEVELS+1];
    assign mode_ok    = (mode == 3'b000) || (mode == 3'b010) || (mode == 3'b110);

    // Per-mode pair count and result width: sx = 16 - B drops unused MSBs of mac_z
    always_comb begin
        last_pair = 2'd0;
        sx        = 3'd0;
        case (mode_q)
            3'b010:  begin last_pair = 2'd3; sx = 3'd6; end
            3'b110:  begin last_pair = 2'd1; sx = 3'd3; end
            default: begin last_pair = 2'd0; sx = 3'd0; end
        endcase
        z_shl = mac_z << sx;
        z_ext = $signed(z_shl) >>> sx;
    end

    // Pack word with the currently offered pair merged in; first pair lands in the MS field
    always_comb begin
        w_nxt = w_pack;
        a_nxt = a_pack;
        case (mode_q)
            3'b010: begin
                w_nxt[{~pcnt, 2'b00} +: 4] = in_w[3:0];
                a_nxt[{~pcnt, 2'b00} +: 4] = in_a[3:0];
            end
            3'b110: begin
                if (!pcnt[0]) begin
                    w_nxt[7:4]  = in_w[3:0];
                    a_nxt[15:8] = in_a;
                end else begin
                    w_nxt[3:0]  = in_w[3:0];
                    a_nxt[7:0]  = in_a;
                end
            end
            default: begin
                w_nxt = {8'h00, in_w};
                a_nxt = {8'h00, in_a};
            end
        endcase
    end

    // Sequencer FSM; every output is registered and set for the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mode_q       <= 3'b000;
            pcnt         <= '0;
            ops          <= '0;
            dcnt         <= '0;
            w_pack       <= '0;
            a_pack       <= '0;
            in_ready     <= 1'b0;
            mac_a        <= '0;
            mac_w        <= '0;
            mac_accu_rst <= 1'b0;
            res_z        <= '0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err      <= 1'b0;
            res_valid    <= 1'b0;
            mac_accu_rst <= 1'b0;
            mac_a        <= '0;
            mac_w        <= '0;
            case (state)
                IDLE: if (start) begin
                    if (mode_ok) begin
                        mode_q       <= mode;
                        state        <= CLEAR;
                        busy         <= 1'b1;
                        mac_accu_rst <= 1'b1;
                        ops          <= '0;
                        pcnt         <= '0;
                        w_pack       <= '0;
                        a_pack       <= '0;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end
                CLEAR: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
                FILL: if (in_valid && in_ready) begin
                    if (pcnt == last_pair) begin
                        mac_w    <= w_nxt;
                        mac_a    <= a_nxt;
                        w_pack   <= '0;
                        a_pack   <= '0;
                        pcnt     <= '0;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end else begin
                        w_pack <= w_nxt;
                        a_pack <= a_nxt;
                        pcnt   <= pcnt + 2'd1;
                    end
                end
                ISSUE: begin
                    ops <= ops + 10'd1;
                    if (ops == LAST_OP) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    // result registered on entry to DONE so res_z and res_valid appear together
                    if (dcnt == LAST_DRAIN) begin
                        state     <= DONE;
                        res_z     <= z_ext;
                        res_valid <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bfusion_operand_sequencer.sv
// Bench for bfusion_operand_sequencer: two instances (ACCU_LEN 1 and 2) each
// driving a behavioural bit-fusion MAC; fixed vectors, corner sequences and
// randomized runs against an arithmetic reference model.
module tb_bfusion_operand_sequencer;
    localparam int H = 4, MAC_LAT = 2, ZW = 16 + H;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    mode[2];
    logic          start[2], in_valid[2], in_ready[2];
    logic [7:0]    in_w[2], in_a[2];
    logic [15:0]   mac_a[2], mac_w[2];
    logic [2:0]    mac_config[2];
    logic          mac_accu_rst[2];
    logic [ZW-1:0] res_z[2];
    logic          res_valid[2], busy[2], cfg_err[2];
    logic signed [ZW-1:0] acc[2], zp[2];

    bfusion_operand_sequencer #(.HEADROOM(H), .SCALABLE_LEVELS(2), .ACCU_LEN(1), .MAC_LAT(MAC_LAT)) u_len1 (
        .clk(clk), .rst(rst), .mode(mode[0]), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_w(in_w[0]), .in_a(in_a[0]), .mac_a(mac_a[0]), .mac_w(mac_w[0]),
        .mac_config(mac_config[0]), .mac_accu_rst(mac_accu_rst[0]), .mac_z(zp[0]), .res_z(res_z[0]),
        .res_valid(res_valid[0]), .busy(busy[0]), .cfg_err(cfg_err[0]));

    bfusion_operand_sequencer #(.HEADROOM(H), .SCALABLE_LEVELS(2), .ACCU_LEN(2), .MAC_LAT(MAC_LAT)) u_len2 (
        .clk(clk), .rst(rst), .mode(mode[1]), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_w(in_w[1]), .in_a(in_a[1]), .mac_a(mac_a[1]), .mac_w(mac_w[1]),
        .mac_config(mac_config[1]), .mac_accu_rst(mac_accu_rst[1]), .mac_z(zp[1]), .res_z(res_z[1]),
        .res_valid(res_valid[1]), .busy(busy[1]), .cfg_err(cfg_err[1]));

    // Dot product of the packed fields: signed weights times unsigned activations
    function automatic int mac_dot(input logic [15:0] w, input logic [15:0] a, input logic [2:0] cfg);
        int s;
        s = 0;
        case (cfg)
            3'b010:  for (int i = 0; i < 4; i++) s += int'($signed(w[4*i +: 4])) * int'(a[4*i +: 4]);
            3'b110:  s = int'($signed(w[7:4])) * int'(a[15:8]) + int'($signed(w[3:0])) * int'(a[7:0]);
            default: s = int'($signed(w[7:0])) * int'(a[7:0]);
        endcase
        return s;
    endfunction

    // MAC model: accumulate in one cycle, one more register stage gives a 2-cycle latency
    always @(posedge clk or negedge rst)
        for (int d = 0; d < 2; d++)
            if (!rst) begin
                acc[d] <= '0;
                zp[d]  <= '0;
            end else begin
                acc[d] <= mac_accu_rst[d] ? '0 : acc[d] + ZW'(mac_dot(mac_w[d], mac_a[d], mac_config[d]));
                zp[d]  <= acc[d];
            end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string nm);
        chk(nm, 64'({in_ready[d], mac_a[d], mac_w[d], mac_config[d], mac_accu_rst[d], res_z[d],
                     res_valid[d], busy[d], cfg_err[d]}), 64'd0);
    endtask

    function automatic int pairs_of(input logic [2:0] m);
        case (m)
            3'b010:  return 4;
            3'b110:  return 2;
            default: return 1;
        endcase
    endfunction

    // run description and expectations
    logic [2:0]    r_mode;
    int            r_n;
    logic [7:0]    r_w[8], r_a[8];
    int            r_gap[8];
    logic [15:0]   e_w[2], e_a[2];
    logic [ZW-1:0] e_z;
    int            e_ops;
    bit            r_noise;
    int            stall_rdy;

    // Reference: packed words by field arithmetic, result = sum of products wrapped to B+H bits
    task automatic model(input int accu);
        int p, tot, wd, m, v, sw, ua, wv, av, i;
        p = pairs_of(r_mode); r_n = accu * p; e_ops = accu; tot = 0;
        for (int o = 0; o < accu; o++) begin
            e_w[o] = '0; e_a[o] = '0;
            for (int k = 0; k < p; k++) begin
                i = o * p + k; wv = int'(r_w[i]); av = int'(r_a[i]);
                if (p == 1) begin
                    e_w[o] = 16'(wv); e_a[o] = 16'(av);
                    sw = (wv >= 128) ? wv - 256 : wv; ua = av;
                end else if (p == 4) begin
                    e_w[o] += 16'((wv % 16) << (4 * (3 - k)));
                    e_a[o] += 16'((av % 16) << (4 * (3 - k)));
                    sw = (wv % 16 >= 8) ? wv % 16 - 16 : wv % 16; ua = av % 16;
                end else begin
                    e_w[o] += 16'((wv % 16) << (4 * (1 - k)));
                    e_a[o] += 16'(av << (8 * (1 - k)));
                    sw = (wv % 16 >= 8) ? wv % 16 - 16 : wv % 16; ua = av;
                end
                tot += sw * ua;
            end
        end
        wd = ((p == 1) ? 16 : (p == 4) ? 10 : 13) + H;
        m = 1 << wd; v = tot & (m - 1);
        if (v >= m / 2) v -= m;
        e_z = ZW'(v);
    endtask

    task automatic run(input int d, input string nm);
        int idx, op, gapc, cyc, cyc_iss, stray, nrst, ncfg, p;
        bit done, acc_now;
        p = pairs_of(r_mode); idx = 0; op = 0; gapc = r_gap[0]; cyc = 0; cyc_iss = 0;
        stray = 0; nrst = 0; ncfg = 0; done = 0; stall_rdy = 0;
        mode[d] = r_mode; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk({nm, " clear"}, 64'({busy[d], mac_accu_rst[d], in_ready[d], mac_w[d], mac_a[d], mac_config[d]}),
            64'({1'b1, 1'b1, 1'b0, 16'h0, 16'h0, r_mode}));
        while (!done && cyc < 300) begin
            if (r_noise) begin start[d] = 1'($urandom); mode[d] = 3'($urandom); end
            if (idx < r_n && gapc > 0) begin
                in_valid[d] = 1'b0; gapc--;
                if (in_ready[d]) stall_rdy++;
            end else if (idx < r_n) begin
                in_valid[d] = 1'b1; in_w[d] = r_w[idx]; in_a[d] = r_a[idx];
            end else in_valid[d] = 1'b0;
            if (idx < r_n && idx % p != 0) chk({nm, " ready mid-op"}, 64'(in_ready[d]), 64'd1);
            acc_now = in_valid[d] && in_ready[d];
            @(negedge clk);
            cyc++;
            if (acc_now) begin idx++; gapc = (idx < r_n) ? r_gap[idx] : 0; end
            if (acc_now && idx % p == 0 && op < e_ops) begin
                chk($sformatf("%s issue%0d", nm, op), 64'({mac_w[d], mac_a[d], mac_accu_rst[d]}),
                    64'({e_w[op], e_a[op], 1'b0}));
                op++; cyc_iss = cyc;
            end else if (mac_w[d] != 16'h0 || mac_a[d] != 16'h0) stray++;
            if (mac_accu_rst[d]) nrst++;
            if (cfg_err[d]) ncfg++;
            if (res_valid[d]) begin
                chk({nm, " res_z"}, 64'(res_z[d]), 64'(e_z));
                chk({nm, " latency"}, 64'(cyc - cyc_iss), 64'(MAC_LAT + 1));
                done = 1'b1;
            end
        end
        start[d] = 1'b0; in_valid[d] = 1'b0;
        chk({nm, " completed"}, 64'(done), 64'd1);
        chk({nm, " op count"}, 64'(op), 64'(e_ops));
        chk({nm, " stray words/clears/errs"}, 64'(stray + nrst + ncfg), 64'd0);
        @(negedge clk);
        chk({nm, " after"}, 64'({res_valid[d], busy[d], in_ready[d], res_z[d]}), 64'({3'b000, e_z}));
    endtask

    typedef struct packed {
        logic [2:0]      md;
        logic [2:0]      n;
        logic [3:0][7:0] w;
        logic [3:0][7:0] a;
        logic [15:0]     xw;
        logic [15:0]     xa;
        logic [ZW-1:0]   xz;
    } vec_t;
    vec_t tbl[7];

    task automatic load_row(input int i);
        r_mode = tbl[i].md; r_n = int'(tbl[i].n); r_noise = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r_gap[k] = 0;
            r_w[k] = (k < 4) ? tbl[i].w[k] : 8'h00;
            r_a[k] = (k < 4) ? tbl[i].a[k] : 8'h00;
        end
        r_gap[1] = i % 2;
        e_w[0] = tbl[i].xw; e_a[0] = tbl[i].xa; e_z = tbl[i].xz; e_ops = 1;
    endtask

    logic [2:0] bad_modes[2];
    int rd, raccu;

    initial begin
        for (int d = 0; d < 2; d++) begin
            mode[d] = '0; start[d] = 1'b0; in_valid[d] = 1'b0; in_w[d] = '0; in_a[d] = '0;
        end
        tbl[0] = '{3'b010, 3'd4, {8'hF8, 8'hF8, 8'hF8, 8'hF8}, {8'h0F, 8'h0F, 8'h0F, 8'h0F}, 16'h8888, 16'hFFFF, -20'sd480};
        tbl[1] = '{3'b110, 3'd2, {8'h00, 8'h00, 8'hF8, 8'h07}, {8'h00, 8'h00, 8'hFF, 8'hFF}, 16'h0078, 16'hFFFF, -20'sd255};
        tbl[2] = '{3'b000, 3'd1, {8'h00, 8'h00, 8'h00, 8'hFD}, {8'h00, 8'h00, 8'h00, 8'h05}, 16'h00FD, 16'h0005, -20'sd15};
        tbl[3] = '{3'b000, 3'd1, {8'h00, 8'h00, 8'h00, 8'h80}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'h0080, 16'h00FF, -20'sd32640};
        tbl[4] = '{3'b010, 3'd4, {8'h0F, 8'h03, 8'h02, 8'h01}, {8'h0F, 8'h03, 8'h02, 8'h01}, 16'h123F, 16'h123F, -20'sd1};
        tbl[5] = '{3'b110, 3'd2, {8'h00, 8'h00, 8'h03, 8'hFF}, {8'h00, 8'h00, 8'h01, 8'h80}, 16'h00F3, 16'h8001, -20'sd125};
        tbl[6] = '{3'b010, 3'd4, {8'h17, 8'h17, 8'h17, 8'h17}, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 16'h7777, 16'h5555, 20'sd140};

        // reset state
        @(negedge clk); @(negedge clk);
        chk_zero(0, "reset len1");
        chk_zero(1, "reset len2");
        rst = 1'b1;
        @(negedge clk);

        // fixed single-op vectors on the ACCU_LEN=1 instance
        for (int i = 0; i < 7; i++) begin
            load_row(i);
            run(0, $sformatf("tbl%0d", i));
        end

        // two-op run, then the same with a 3-cycle in_valid gap
        for (int g = 0; g < 2; g++) begin
            r_mode = 3'b000; r_n = 2; r_noise = 1'b0;
            for (int k = 0; k < 8; k++) r_gap[k] = 0;
            r_w[0] = 8'hFD; r_a[0] = 8'h05; r_w[1] = 8'h07; r_a[1] = 8'h02;
            r_gap[1] = 3 * g;
            e_w[0] = 16'h00FD; e_a[0] = 16'h0005; e_w[1] = 16'h0007; e_a[1] = 16'h0002;
            e_z = -20'sd1; e_ops = 2;
            run(1, g ? "gap run" : "two-op run");
            if (g == 1) chk("gap run ready during stall", 64'(stall_rdy), 64'd2);
        end

        // illegal modes: cfg_err pulse only
        bad_modes[0] = 3'b001; bad_modes[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            mode[1] = bad_modes[i]; start[1] = 1'b1;
            @(negedge clk);
            start[1] = 1'b0; mode[1] = 3'b000;
            chk($sformatf("bad mode %0d strobe", i), 64'({cfg_err[1], busy[1], mac_accu_rst[1]}), 64'b100);
            @(negedge clk);
            chk($sformatf("bad mode %0d strobe end", i), 64'({cfg_err[1], busy[1], mac_accu_rst[1]}), 64'b000);
        end

        // randomized runs with input noise on start/mode while busy
        for (int it = 0; it < 24; it++) begin
            rd = it % 2; raccu = rd + 1;
            case ($urandom_range(0, 2))
                0:       r_mode = 3'b000;
                1:       r_mode = 3'b010;
                default: r_mode = 3'b110;
            endcase
            for (int k = 0; k < 8; k++) begin
                r_w[k] = 8'($urandom); r_a[k] = 8'($urandom) | 8'h01;
                r_gap[k] = int'($urandom_range(0, 2));
            end
            r_noise = 1'b1;
            model(raccu);
            run(rd, $sformatf("rand%0d", it));
        end

        // reset in the middle of FILL after two accepted pairs
        mode[0] = 3'b010; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; in_valid[0] = 1'b1; in_w[0] = 8'h03; in_a[0] = 8'h05;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("midrun busy/ready", 64'({busy[0], in_ready[0]}), 64'b11);
        in_valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero(0, "midrun reset len1");
        chk_zero(1, "midrun reset len2");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_row(0);
        run(0, "post-reset run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
